// File: rtl/ccff_loader.sv
// Configuration-chain loader: serialises host words MSB-first onto ccff_head with a
// per-cycle shift enable, and optionally checks ccff_tail against a resent stream.
module ccff_loader #(
  parameter int WORD_WIDTH   = 8,
  parameter int CHAIN_LENGTH = 12,
  parameter int CNT_WIDTH    = $clog2(CHAIN_LENGTH + 1)
) (
  input  logic                  prog_clk,
  input  logic                  prog_reset,
  input  logic                  start,
  input  logic                  verify,
  input  logic [WORD_WIDTH-1:0] word_in,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic                  ccff_head,
  output logic                  prog_clk_en,
  input  logic                  ccff_tail,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int SC_WIDTH = $clog2(WORD_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_t;

  state_t                state, state_next;
  logic [WORD_WIDTH-1:0] sr, sr_next;
  logic [SC_WIDTH-1:0]   sr_cnt, sr_cnt_next;
  logic [CNT_WIDTH-1:0]  bits_left, bits_left_next;
  logic                  vmode, vmode_next;
  logic                  error_next;
  logic                  head_next;
  logic                  en_next;
  logic                  accept;
  logic                  shift;
  int unsigned           avail;

  assign busy = (state == LOAD);
  assign done = (state == DONE);

  always_comb begin
    word_ready     = (state == LOAD) && (sr_cnt <= SC_WIDTH'(1)) &&
                     (32'(bits_left) > 32'(sr_cnt));
    accept         = word_ready && word_valid;
    shift          = (state == LOAD) && (bits_left != '0) && ((sr_cnt != '0) || accept);
    state_next     = state;
    sr_next        = sr;
    sr_cnt_next    = sr_cnt;
    bits_left_next = bits_left;
    vmode_next     = vmode;
    error_next     = error;
    head_next      = ccff_head;
    en_next        = 1'b0;
    avail          = 0;

    // Compare at the edge that clocks the chain, using the bit currently presented.
    if (vmode && prog_clk_en && (ccff_tail != ccff_head))
      error_next = 1'b1;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_next     = LOAD;
          bits_left_next = CNT_WIDTH'(CHAIN_LENGTH);
          sr_cnt_next    = '0;
          vmode_next     = verify;
          error_next     = 1'b0;
        end
      end
      LOAD: begin
        if (bits_left == '0) begin
          state_next = DONE;
        end else if (shift) begin
          en_next        = 1'b1;
          bits_left_next = bits_left - CNT_WIDTH'(1);
          if (sr_cnt == '0) begin
            // Empty holding register: the new word's MSB goes straight out this edge,
            // so a stalled host costs no extra cycle once it resumes.
            head_next = word_in[WORD_WIDTH-1];
            sr_next   = WORD_WIDTH'({word_in, 1'b0});
            avail     = (32'(bits_left) < 32'(WORD_WIDTH)) ? 32'(bits_left) - 1
                                                           : 32'(WORD_WIDTH) - 1;
          end else begin
            head_next = sr[WORD_WIDTH-1];
            if (accept) begin
              sr_next = word_in;
              avail   = (32'(bits_left) - 1 < 32'(WORD_WIDTH)) ? 32'(bits_left) - 1
                                                                : 32'(WORD_WIDTH);
            end else begin
              sr_next = WORD_WIDTH'({sr, 1'b0});
              avail   = 32'(sr_cnt) - 1;
            end
          end
          sr_cnt_next = SC_WIDTH'(avail);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      state       <= IDLE;
      sr          <= '0;
      sr_cnt      <= '0;
      bits_left   <= '0;
      vmode       <= 1'b0;
      error       <= 1'b0;
      ccff_head   <= 1'b0;
      prog_clk_en <= 1'b0;
    end else begin
      state       <= state_next;
      sr          <= sr_next;
      sr_cnt      <= sr_cnt_next;
      bits_left   <= bits_left_next;
      vmode       <= vmode_next;
      error       <= error_next;
      ccff_head   <= head_next;
      prog_clk_en <= en_next;
    end
  end

endmodule
